// File: rtl/imm_encoder.sv
// ============================================================================
// Module   : imm_encoder
// Purpose  : Packs immediate + register/funct fields into an RV32 instruction
//            word, with optional LUI+ADDI load-immediate expansion.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_encoder (
    input  logic        CLK,
    input  logic        RST,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_opcode,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_imm,
    input  logic        in_li,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_last,
    output logic        out_err
);

    localparam logic [4:0] C_OP_LOAD0  = 5'b00000;
    localparam logic [4:0] C_OP_LOAD1  = 5'b00001;
    localparam logic [4:0] C_OP_OPIMM  = 5'b00100;
    localparam logic [4:0] C_OP_AUIPC  = 5'b00101;
    localparam logic [4:0] C_OP_STORE0 = 5'b01000;
    localparam logic [4:0] C_OP_STORE1 = 5'b01001;
    localparam logic [4:0] C_OP_LUI    = 5'b01101;
    localparam logic [4:0] C_OP_BRANCH = 5'b11000;
    localparam logic [4:0] C_OP_JALR   = 5'b11001;
    localparam logic [4:0] C_OP_JAL    = 5'b11011;

    localparam logic [6:0] C_LUI_OPC   = 7'b0110111;
    localparam logic [6:0] C_ADDI_OPC  = 7'b0010011;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic        out_last_q, out_last_d;
    logic        out_err_q, out_err_d;
    logic [31:0] pend_instr_q, pend_instr_d;

    logic        w_ok_i, w_ok_b, w_ok_j, w_ok_u;
    logic [6:0]  w_base;
    logic [19:0] w_li_hi;
    logic [11:0] w_li_lo;
    logic [31:0] w_enc_instr;
    logic [31:0] w_pend_instr;
    logic        w_enc_err;
    logic        w_two_word;
    logic        w_fire;
    logic        w_pop;

    assign w_ok_i  = (in_imm[31:11] == {21{in_imm[11]}});
    assign w_ok_b  = (in_imm[31:12] == {20{in_imm[12]}}) & ~in_imm[0];
    assign w_ok_j  = (in_imm[31:20] == {12{in_imm[20]}}) & ~in_imm[0];
    assign w_ok_u  = (in_imm[11:0] == 12'd0);
    assign w_base  = {in_opcode, 2'b11};
    assign w_li_lo = in_imm[11:0];
    // Round the upper part so that sign-extended ADDI lo lands on the target.
    assign w_li_hi = in_imm[31:12] + {19'd0, in_imm[11]};

    always_comb begin
        w_enc_instr  = 32'd0;
        w_pend_instr = 32'd0;
        w_enc_err    = 1'b0;
        w_two_word   = 1'b0;
        if (in_li) begin
            if (w_li_lo == 12'd0) begin
                w_enc_instr = {w_li_hi, in_rd, C_LUI_OPC};
            end else if (w_li_hi == 20'd0) begin
                w_enc_instr = {w_li_lo, 5'd0, 3'b000, in_rd, C_ADDI_OPC};
            end else begin
                w_enc_instr  = {w_li_hi, in_rd, C_LUI_OPC};
                w_pend_instr = {w_li_lo, in_rd, 3'b000, in_rd, C_ADDI_OPC};
                w_two_word   = 1'b1;
            end
        end else begin
            case (in_opcode)
                C_OP_JAL: begin
                    w_enc_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                                   in_rd, w_base};
                    w_enc_err   = ~w_ok_j;
                end
                C_OP_LUI, C_OP_AUIPC: begin
                    w_enc_instr = {in_imm[31:12], in_rd, w_base};
                    w_enc_err   = ~w_ok_u;
                end
                C_OP_OPIMM, C_OP_JALR, C_OP_LOAD0, C_OP_LOAD1: begin
                    w_enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, w_base};
                    w_enc_err   = ~w_ok_i;
                end
                C_OP_BRANCH: begin
                    w_enc_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                                   in_imm[4:1], in_imm[11], w_base};
                    w_enc_err   = ~w_ok_b;
                end
                C_OP_STORE0, C_OP_STORE1: begin
                    w_enc_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0],
                                   w_base};
                    w_enc_err   = ~w_ok_i;
                end
                default: begin
                    w_enc_instr = 32'd0;
                    w_enc_err   = 1'b1;
                end
            endcase
        end
    end

    assign in_ready = (state_q == ST_IDLE) & (~out_valid_q | out_ready);
    assign w_fire   = in_valid & in_ready;
    assign w_pop    = out_valid_q & out_ready;

    always_comb begin
        state_d      = state_q;
        out_valid_d  = out_valid_q;
        out_instr_d  = out_instr_q;
        out_last_d   = out_last_q;
        out_err_d    = out_err_q;
        pend_instr_d = pend_instr_q;
        case (state_q)
            ST_IDLE: begin
                if (w_fire) begin
                    out_valid_d = 1'b1;
                    out_instr_d = w_enc_instr;
                    out_last_d  = ~w_two_word;
                    out_err_d   = w_enc_err;
                    if (w_two_word) begin
                        state_d      = ST_PEND;
                        pend_instr_d = w_pend_instr;
                    end
                end else if (w_pop) begin
                    out_valid_d = 1'b0;
                end
            end
            ST_PEND: begin
                // LUI word is on the output; swap in the held ADDI once it leaves.
                if (w_pop) begin
                    out_instr_d = pend_instr_q;
                    out_last_d  = 1'b1;
                    out_err_d   = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            out_valid_q  <= 1'b0;
            out_instr_q  <= 32'd0;
            out_last_q   <= 1'b0;
            out_err_q    <= 1'b0;
            pend_instr_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            out_instr_q  <= out_instr_d;
            out_last_q   <= out_last_d;
            out_err_q    <= out_err_d;
            pend_instr_q <= pend_instr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_last  = out_last_q;
    assign out_err   = out_err_q;

endmodule

`default_nettype wire
